// File: rtl/seq_detect_prog.sv
// seq_detect_prog
// Programmable serial sequence detector. Watches a qualified serial stream and
// emits a one-cycle pulse on dout each time the configured pattern completes.
// The pattern is right-aligned: bit [len-1] is the first bit received and
// bit [0] is the most recent one. Length, pattern and overlap mode can be
// reloaded at runtime. A saturating match counter is included.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   din          serial data bit
//   din_valid    din qualifier; unqualified cycles are ignored entirely
//   cfg_load     latch cfg_* and restart detection (din discarded that cycle)
//   cfg_pattern  pattern, right-aligned
//   cfg_len      pattern length (clamped to MAX_LEN, 0 disables)
//   cfg_overlap  1 = overlapping matches, 0 = each match needs len fresh bits
//   clr_cnt      clear match counter (wins over a simultaneous increment)
//   dout         registered one-cycle match pulse
//   match_cnt    saturating match count
//   cnt_sat      match_cnt is all-ones
//   armed        the next valid bit can complete a match
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | len == 0, detector disabled
// ST_FILL  | fewer than len-1 fresh bits collected
// ST_ARMED | len-1 or more fresh bits; next valid bit may complete a match
module seq_detect_prog #(
  parameter int                   MAX_LEN     = 8,
  parameter int                   CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]   DEF_PATTERN = 8'b0000_0110,
  parameter int                   DEF_LEN     = 3,
  parameter logic                 DEF_OVERLAP = 1'b1,
  localparam int                  LW          = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_cnt,
  output logic               dout,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat,
  output logic               armed
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ARMED = 2'd2
  } state_t;

  localparam logic [LW-1:0] MAX_LEN_C = LW'(MAX_LEN);
  localparam logic [LW-1:0] DEF_LEN_C = LW'(DEF_LEN);

  // Starting state after a restart with a given length: a single-bit pattern
  // needs no history, so it is armed straight away.
  function automatic state_t start_state(input logic [LW-1:0] len);
    if (len == '0)
      return ST_IDLE;
    else if (len == LW'(1))
      return ST_ARMED;
    else
      return ST_FILL;
  endfunction

  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LW-1:0] len);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LW'(i) < len) m[i] = 1'b1;
    end
    return m;
  endfunction

  state_t               state_q, state_d;
  // Only MAX_LEN-1 bits of history are ever needed: the newest bit of a
  // match is din itself.
  logic [MAX_LEN-2:0]   hist_q, hist_d;
  logic [LW-1:0]        fill_q, fill_d;
  logic [MAX_LEN-1:0]   pat_q, pat_d;
  logic [LW-1:0]        len_q, len_d;
  logic                 ovl_q, ovl_d;
  logic                 dout_q, dout_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [MAX_LEN-1:0]   shifted;
  logic [MAX_LEN-1:0]   mask;
  logic [LW-1:0]        len_cl;
  logic [LW-1:0]        fill_inc;
  logic                 match;

  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    cnt_d    = cnt_q;
    match    = 1'b0;
    shifted  = {hist_q, din};
    mask     = len_mask(len_q);
    len_cl   = (cfg_len > MAX_LEN_C) ? MAX_LEN_C : cfg_len;
    // fill saturates at MAX_LEN so it cannot wrap during long overlap runs
    fill_inc = (fill_q >= MAX_LEN_C) ? fill_q : fill_q + LW'(1);

    if (cfg_load) begin
      pat_d   = cfg_pattern;
      len_d   = len_cl;
      ovl_d   = cfg_overlap;
      hist_d  = '0;
      fill_d  = '0;
      state_d = start_state(len_cl);
    end else if (din_valid && state_q != ST_IDLE) begin
      hist_d = shifted[MAX_LEN-2:0];
      match  = (state_q == ST_ARMED) && (((shifted ^ pat_q) & mask) == '0);
      if (match && !ovl_q) begin
        fill_d  = '0;
        state_d = (len_q == LW'(1)) ? ST_ARMED : ST_FILL;
      end else begin
        fill_d = fill_inc;
        // len_q >= 1 whenever the state is not IDLE, so len_q-1 cannot wrap
        if (fill_inc >= len_q - LW'(1)) state_d = ST_ARMED;
      end
    end

    dout_d = match;

    if (clr_cnt)
      cnt_d = '0;
    else if (match && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= start_state(DEF_LEN_C);
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= DEF_PATTERN;
      len_q   <= DEF_LEN_C;
      ovl_q   <= DEF_OVERLAP;
      dout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout      = dout_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = &cnt_q;
  assign armed     = (state_q == ST_ARMED);

endmodule

// File: tb/tb_seq_detect_prog.sv
// Testbench for seq_detect_prog. Two instances share all inputs: the default
// build and a CNT_W=2 build for counter saturation. A reference model keeps
// the received bits in a queue plus a count of fresh bits since the last
// restart, and decides matches directly from the pattern definition.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = 8'h00;
  logic [3:0] cfg_len = 4'd0;
  logic       cfg_overlap = 1'b0;
  logic       clr_cnt = 1'b0;

  logic       dout, cnt_sat, armed;
  logic [7:0] match_cnt;
  logic       dout2, cnt_sat2, armed2;
  logic [1:0] match_cnt2;

  seq_detect_prog u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .clr_cnt(clr_cnt),
    .dout(dout), .match_cnt(match_cnt), .cnt_sat(cnt_sat), .armed(armed)
  );

  seq_detect_prog #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .clr_cnt(clr_cnt),
    .dout(dout2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2), .armed(armed2)
  );

  always #5 clk = ~clk;

  logic [15:0] obs_vec;
  assign obs_vec = {dout, match_cnt, cnt_sat, armed, dout2, match_cnt2, cnt_sat2, armed2};

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [7:0] m_pat;
  int         m_len;
  logic       m_ov;
  int         m_nfresh;
  bit         m_bits[$];
  logic       exp_dout;
  logic       exp_armed;
  int         exp_cnt;
  int         exp_cnt2;

  function automatic logic [15:0] exp_vec();
    logic [7:0] c8;
    logic [1:0] c2;
    c8 = 8'(exp_cnt);
    c2 = 2'(exp_cnt2);
    return {exp_dout, c8, (exp_cnt == 255), exp_armed,
            exp_dout, c2, (exp_cnt2 == 3), exp_armed};
  endfunction

  task automatic model_edge(input logic v, input logic d, input logic l,
                            input logic c, input logic r, input logic [7:0] p,
                            input logic [3:0] ln, input logic o);
    logic m;
    m = 1'b0;
    if (r) begin
      m_pat = 8'b0000_0110; m_len = 3; m_ov = 1'b1; m_nfresh = 0;
      m_bits.delete(); exp_cnt = 0; exp_cnt2 = 0;
    end else begin
      if (l) begin
        m_pat = p; m_len = (ln > 4'd8) ? 8 : int'(ln); m_ov = o; m_nfresh = 0;
      end else if (v && m_len > 0) begin
        m_bits.push_back(d);
        if (m_bits.size() > 16) void'(m_bits.pop_front());
        m_nfresh++;
        if (m_nfresh >= m_len) begin
          m = 1'b1;
          // k bits back from the newest must equal pattern bit k
          for (int k = 0; k < m_len; k++)
            if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) m = 1'b0;
        end
        if (m && !m_ov) m_nfresh = 0;
      end
      if (c) begin
        exp_cnt = 0; exp_cnt2 = 0;
      end else if (m) begin
        if (exp_cnt < 255) exp_cnt++;
        if (exp_cnt2 < 3) exp_cnt2++;
      end
    end
    exp_dout  = m;
    exp_armed = (m_len > 0) && (m_nfresh >= m_len - 1);
  endtask

  task automatic step(input logic v, input logic d, input logic l,
                      input logic c, input logic r);
    din_valid = v; din = d; cfg_load = l; clr_cnt = c; rst = r;
    model_edge(v, d, l, c, r, cfg_pattern, cfg_len, cfg_overlap);
    @(posedge clk);
    #1;
    din_valid = 1'b0; cfg_load = 1'b0; clr_cnt = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    if (obs_vec !== 16'h0000) begin
      errors++; $display("FAIL reset_state: got %h want %h", obs_vec, 16'h0000);
    end
    checks++;
    if (obs_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_model: got %h want %h", obs_vec, exp_vec());
    end
    checks++;
  endtask

  task automatic test_default_stream();
    bit s[9] = '{0, 0, 1, 1, 0, 1, 1, 0, 1};
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, s[i], 1'b0, 1'b0, 1'b0);
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL default_110 bit%0d: got %h want %h", i + 1, obs_vec, exp_vec());
      end
      checks++;
      if (dout !== 1'((i == 4) || (i == 7))) begin
        errors++; $display("FAIL default_110_pulse bit%0d: got %b", i + 1, dout);
      end
      checks++;
    end
    if (match_cnt !== 8'd2) begin
      errors++; $display("FAIL default_110_cnt: got %0d want 2", match_cnt);
    end
    checks++;
  endtask

  task automatic test_1101();
    bit s[7] = '{1, 1, 0, 1, 1, 0, 1};
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int pass = 0; pass < 2; pass++) begin
      cfg_pattern = 8'b0000_1101; cfg_len = 4'd4; cfg_overlap = (pass == 0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) begin
        step(1'b1, s[i], 1'b0, 1'b0, 1'b0);
        if (obs_vec !== exp_vec()) begin
          errors++; $display("FAIL p1101 ov=%0d bit%0d: got %h want %h", 1 - pass, i + 1, obs_vec, exp_vec());
        end
        checks++;
        if (dout !== 1'((i == 3) || (pass == 0 && i == 6))) begin
          errors++; $display("FAIL p1101_pulse ov=%0d bit%0d: got %b", 1 - pass, i + 1, dout);
        end
        checks++;
      end
    end
    if (match_cnt !== 8'd3) begin
      errors++; $display("FAIL p1101_cnt: got %0d want 3", match_cnt);
    end
    checks++;
  endtask

  task automatic test_invalid_gaps();
    bit s[3] = '{1, 1, 0};
    int pulses = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, s[i], 1'b0, 1'b0, 1'b0);
      if (dout) pulses++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL gaps bit%0d: got %h want %h", i, obs_vec, exp_vec());
      end
      checks++;
      for (int g = 0; g < 2; g++) begin
        step(1'b0, 1'(g ^ i), 1'b0, 1'b0, 1'b0);
        if (dout) pulses++;
        if (obs_vec !== exp_vec()) begin
          errors++; $display("FAIL gaps idle%0d.%0d: got %h want %h", i, g, obs_vec, exp_vec());
        end
        checks++;
      end
    end
    if (pulses != 1 || match_cnt !== 8'd1) begin
      errors++; $display("FAIL gaps_count: pulses %0d cnt %0d want 1 1", pulses, match_cnt);
    end
    checks++;
  endtask

  task automatic test_saturation();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cfg_pattern = 8'b0000_0001; cfg_len = 4'd1; cfg_overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL sat match%0d: got %h want %h", i + 1, obs_vec, exp_vec());
      end
      checks++;
      if (cnt_sat2 !== 1'(i >= 2)) begin
        errors++; $display("FAIL sat_flag match%0d: got %b", i + 1, cnt_sat2);
      end
      checks++;
    end
    if (match_cnt2 !== 2'd3 || match_cnt !== 8'd5) begin
      errors++; $display("FAIL sat_cnt: got %0d/%0d want 3/5", match_cnt2, match_cnt);
    end
    checks++;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    if (dout2 !== 1'b1 || match_cnt2 !== 2'd0 || cnt_sat2 !== 1'b0 || match_cnt !== 8'd0) begin
      errors++; $display("FAIL clr_with_match: dout %b cnt %0d sat %b want 1 0 0", dout2, match_cnt2, cnt_sat2);
    end
    checks++;
  endtask

  task automatic test_rst_mid_and_idle();
    bit s[6] = '{1, 1, 0, 1, 1, 0};
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    if (dout !== 1'b0 || obs_vec !== exp_vec()) begin
      errors++; $display("FAIL rst_mid: got %h want %h", obs_vec, exp_vec());
    end
    checks++;
    cfg_pattern = 8'b0000_0110; cfg_len = 4'd0; cfg_overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, s[i], 1'b0, 1'b0, 1'b0);
      if (armed !== 1'b0 || dout !== 1'b0 || obs_vec !== exp_vec()) begin
        errors++; $display("FAIL idle_len0 bit%0d: got %h want %h", i, obs_vec, exp_vec());
      end
      checks++;
    end
  endtask

  task automatic test_clamp_and_load_collision();
    logic [7:0] p = 8'b1011_0010;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cfg_pattern = p; cfg_len = 4'd9; cfg_overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, p[7 - i], 1'b0, 1'b0, 1'b0);
      if (dout !== 1'(i == 7) || obs_vec !== exp_vec()) begin
        errors++; $display("FAIL clamp bit%0d: got %h want %h", i + 1, obs_vec, exp_vec());
      end
      checks++;
    end
    cfg_pattern = 8'b0000_0110; cfg_len = 4'd3; cfg_overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    if (dout !== 1'b0 || armed !== 1'b0 || obs_vec !== exp_vec()) begin
      errors++; $display("FAIL load_collision: got %h want %h", obs_vec, exp_vec());
    end
    checks++;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    if (dout !== 1'b1 || obs_vec !== exp_vec()) begin
      errors++; $display("FAIL after_collision: got %h want %h", obs_vec, exp_vec());
    end
    checks++;
  endtask

  task automatic test_random();
    logic r, l, c, v, d;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 499) == 0);
      l = ($urandom_range(0, 39) == 0);
      c = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 3) != 0);
      d = 1'($urandom_range(0, 1));
      if (l) begin
        cfg_pattern = 8'($urandom);
        // short patterns dominate so matches happen often
        cfg_len     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 9))
                                                  : 4'($urandom_range(1, 3));
        cfg_overlap = 1'($urandom_range(0, 1));
      end
      step(v, d, l, c, r);
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL random cyc%0d: got %h want %h", n, obs_vec, exp_vec());
      end
      checks++;
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_default_stream();
    test_1101();
    test_invalid_gaps();
    test_saturation();
    test_rst_mid_and_idle();
    test_clamp_and_load_collision();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
